bin_bcd_display: RTL

BIN_BCD_DISPLAY -- requirements
Module: bin_bcd_display

---
 rtl/bin_bcd_display.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bin_bcd_display.sv
// ============================================================================
// Module   : bin_bcd_display
// Purpose  : Sequential double-dabble binary-to-BCD converter with a
//            multiplexed, active-low seven-segment display driver.
//            Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_bcd_display #(
    parameter int BIN_W       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  bin_in,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);

    localparam int NIB   = (BIN_W + 2) / 3 + 1;
    // Accumulator never narrower than the display so the copy-out is always in range
    localparam int ACC_N = (NIB > DIGITS) ? NIB : DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] C_SEG_DASH  = 7'b0111111;
    localparam logic [6:0] C_SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ACC_N*4-1:0]      r_bcd;
    logic [BIN_W-1:0]        r_bin;
    logic [CNT_W-1:0]        r_cnt;
    logic [DIGITS*4-1:0]     r_disp;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_ovf;
    logic [REF_W-1:0]        r_ref;
    logic [IDX_W-1:0]        r_idx;

    logic [ACC_N*4-1:0]       w_adj;
    logic [ACC_N*4+BIN_W-1:0] w_next;
    logic                     w_ovf;
    logic [3:0]               w_nib;
    logic                     w_blank;
    logic [DIGITS-1:0]        w_an;
    logic [6:0]               w_seg;
    int                       w_lsb;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < ACC_N; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
        w_next = {w_adj, r_bin} << 1;
    end

    always_comb begin
        w_ovf = 1'b0;
        for (int i = DIGITS; i < ACC_N; i++) begin
            if (r_bcd[i*4 +: 4] != 4'd0)
                w_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_bin   <= bin_in;
                        r_bcd   <= '0;
                        r_cnt   <= CNT_W'(BIN_W);
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    {r_bcd, r_bin} <= w_next;
                    r_cnt          <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1))
                        r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_disp  <= r_bcd[DIGITS*4-1:0];
                    r_ovf   <= w_ovf;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Digit scan: each digit stays lit for REFRESH_DIV cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref <= '0;
            r_idx <= '0;
        end else if (r_ref == REF_W'(REFRESH_DIV - 1)) begin
            r_ref <= '0;
            r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_ref <= r_ref + REF_W'(1);
        end
    end

    always_comb begin
        w_lsb     = int'(r_idx) * 4;
        w_nib     = r_disp[w_lsb +: 4];
        w_an      = '1;
        w_an[r_idx] = 1'b0;
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS*4-1:0] w_upper;
    always_comb begin
        w_upper = r_disp >> w_lsb;
        w_blank = (r_idx != '0) && (w_upper == '0);
    end
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_seg = C_SEG_BLANK;
        if (r_ovf) begin
            w_seg = C_SEG_DASH;
        end else if (!w_blank) begin
            case (w_nib)
                4'd0:    w_seg = 7'b1000000;
                4'd1:    w_seg = 7'b1111001;
                4'd2:    w_seg = 7'b0100100;
                4'd3:    w_seg = 7'b0110000;
                4'd4:    w_seg = 7'b0011001;
                4'd5:    w_seg = 7'b0010010;
                4'd6:    w_seg = 7'b0000010;
                4'd7:    w_seg = 7'b1111000;
                4'd8:    w_seg = 7'b0000000;
                4'd9:    w_seg = 7'b0010000;
                default: w_seg = C_SEG_BLANK;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign ovf  = r_ovf;
    assign an   = w_an;
    assign seg  = w_seg;

endmodule

`default_nettype wire
